char_pixel_renderer: RTL and testbench
======================================

Name: char_pixel_renderer

Overview:
- Text-overlay stage that sits between the VGA sync/counter generator and the 4-glyph character ROM.
- Holds a one-line text buffer of glyph codes written by the PS/2 key decoder: 0=F, 1=Q, 2=H, 3=X.
- Per pixel, it drives the ROM address and enable, then consumes the ROM's 8-bit row data.
- It selects the current column bit and emits a pixel-on flag, time-aligned with a delayed video_on, for the colour/PWM stage.

Parameters:
- TEXT_X, 64, left pixel column of the text line.
- TEXT_Y, 32, top pixel row of the text line.
- N_CELLS, 8, number of character cells (1..15); each cell is 8 px wide and 16 px tall.

Ports:
- clk  in  1  pixel clock; pixel_x advances once per cycle.
- rst  in  1  asynchronous, active-high reset.
- pixel_x  in  10  current horizontal pixel from the sync generator.
- pixel_y  in  10  current vertical pixel from the sync generator.
- video_on  in  1  visible-area flag from the sync generator.
- wr_en  in  1  one-cycle strobe: append wr_code at the cursor.
- wr_code  in  2  glyph code to append.
- del  in  1  one-cycle strobe: backspace.
- clr  in  1  one-cycle strobe: empty the buffer.
- rom_addr  out  6  {code[1:0], row[3:0]} to the character ROM.
- rom_en  out  1  ROM char_enable; low forces ROM data to 0.
- rom_data  in  8  ROM row data; the ROM is combinational; bit 7 is the leftmost pixel.
- pixel_on  out  1  glyph pixel lit.
- video_on_out  out  1  video_on delayed to align with pixel_on.
- cursor  out  4  next write cell, range 0..N_CELLS.
- full  out  1  cursor == N_CELLS.
- empty  out  1  cursor == 0.

Behaviour:
- Reset (async, rst=1): all cells invalid with code 0; cursor=0; rom_addr=0; rom_en=0; pixel_on=0; video_on_out=0; internal column register=0.
- Text buffer: N_CELLS entries of {valid, code[1:0]}. The cursor counts 0..N_CELLS and never wraps.
- Buffer update priority per cycle is clr > del > wr_en; only one action occurs per cycle.
  - clr: all cells invalid, cursor=0.
  - del with cursor>0: cell[cursor-1] made invalid, cursor decremented.
  - del with cursor==0: ignored.
  - wr_en with cursor<N_CELLS: cell[cursor]={1,wr_code}, cursor incremented.
  - wr_en with full=1: ignored. The buffer is unchanged and there is no overwrite.
- full and empty are combinational from the cursor.
- Region test (combinational, stage 0):
  - in_x = TEXT_X <= pixel_x < TEXT_X+8*N_CELLS.
  - in_y = TEXT_Y <= pixel_y < TEXT_Y+16.
  - dx = pixel_x-TEXT_X; dy = pixel_y-TEXT_Y.
  - cell = dx[9:3]; col = dx[2:0]; row = dy[3:0].
  - Subtraction is 10-bit unsigned; the region test guards against underflow.
- Stage 1 (registered at the clk edge):
  - rom_addr <= {cell code, row}.
  - rom_en <= video_on & in_x & in_y & cell valid.
  - col_q <= col; von_q <= video_on.
  - Outside the region, rom_addr <= 0 and rom_en <= 0.
- Stage 2 (registered):
  - pixel_on <= rom_en & rom_data[7-col_q].
  - video_on_out <= von_q.
- Latency: pixel (x,y) presented in cycle n gives rom_addr/rom_en valid in cycle n+1 and pixel_on/video_on_out valid in cycle n+2.
- Buffer writes take effect in the cycle after the strobe. A cell written while being scanned may show the new glyph from the next pixel onward; this tear is accepted.
- Reset asserted mid-frame clears the pipeline immediately. After release, the first valid pixel_on is 2 cycles after the first presented pixel.
- No combinational path from pixel_x/pixel_y to any output.

Test Plan:
- Reset, then wr_en with code 0 (F). Present (64,32) with video_on=1 -> cycle+1: rom_addr=6'b000000, rom_en=1. Cycle+2: pixel_on=1 for x=64..71.
- Write F then Q. Scan y=32, x=72..79 -> pixel_on sequence 0,0,0,1,1,0,0,0 (Q row0 = 00011000). Scan y=47, x=72..79 -> 0,0,0,1,1,0,1,1.
- Write 8 codes -> full=1, cursor=8. A 9th wr_en leaves cell7 unchanged. del -> cursor=7, cell7 blank; pixel_on=0 across x=120..127.
- Assert wr_en, del and clr in the same cycle with cursor=3 -> cursor=0 and all cells blank. del at cursor=0 -> cursor stays 0.
- Pixels at (63,32), (128,32), (64,31), (64,48), and (64,32) with video_on=0 -> rom_en=0 and pixel_on=0. video_on_out tracks video_on with a 2-cycle delay.
- Assert rst mid-scan while pixel_on=1 -> pixel_on, rom_en and cursor go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/char_pixel_renderer.sv
// Text-overlay stage: holds a one-line glyph buffer and turns pixel coordinates into ROM lookups and a lit-pixel flag.
// Latency: rom_addr/rom_en one cycle after the pixel, pixel_on/video_on_out two cycles after the pixel.
// Backpressure: none; the pixel stream advances every cycle and buffer strobes are always accepted (or ignored at full/empty).
//
// Ports: clk/rst (async active-high); pixel_x/pixel_y/video_on from the sync generator;
//        wr_en/wr_code/del/clr edit strobes from the key decoder; rom_addr/rom_en/rom_data to/from the
//        combinational character ROM; pixel_on/video_on_out to the colour stage; cursor/full/empty status.
module char_pixel_renderer #(
    parameter int TEXT_X  = 64,
    parameter int TEXT_Y  = 32,
    parameter int N_CELLS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       wr_en,
    input  logic [1:0] wr_code,
    input  logic       del,
    input  logic       clr,
    output logic [5:0] rom_addr,
    output logic       rom_en,
    input  logic [7:0] rom_data,
    output logic       pixel_on,
    output logic       video_on_out,
    output logic [3:0] cursor,
    output logic       full,
    output logic       empty
);

    // Region bounds widened to 11 bits so the upper bound cannot overflow.
    localparam logic [10:0] X_LO = 11'(TEXT_X);
    localparam logic [10:0] X_HI = 11'(TEXT_X + 8 * N_CELLS);
    localparam logic [10:0] Y_LO = 11'(TEXT_Y);
    localparam logic [10:0] Y_HI = 11'(TEXT_Y + 16);
    localparam logic [3:0]  N_C  = 4'(N_CELLS);

    // ------------------------------------------------------------------
    // Text buffer
    // ------------------------------------------------------------------
    logic [N_CELLS-1:0] cell_vld;
    logic [1:0]         cell_code [N_CELLS];
    logic [3:0]         cursor_q;

    assign cursor = cursor_q;
    assign full   = (cursor_q == N_C);
    assign empty  = (cursor_q == 4'd0);

    // One action per cycle: clr wins over del, del wins over wr_en, even when
    // the winning action turns out to be a no-op (del on an empty buffer).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_vld <= '0;
            for (int i = 0; i < N_CELLS; i++) begin
                cell_code[i] <= 2'd0;
            end
            cursor_q <= 4'd0;
        end else if (clr) begin
            cell_vld <= '0;
            cursor_q <= 4'd0;
        end else if (del) begin
            if (cursor_q != 4'd0) begin
                for (int i = 0; i < N_CELLS; i++) begin
                    if (4'(i) == cursor_q - 4'd1) begin
                        cell_vld[i] <= 1'b0;
                    end
                end
                cursor_q <= cursor_q - 4'd1;
            end
        end else if (wr_en) begin
            if (cursor_q != N_C) begin
                for (int i = 0; i < N_CELLS; i++) begin
                    if (4'(i) == cursor_q) begin
                        cell_vld[i]  <= 1'b1;
                        cell_code[i] <= wr_code;
                    end
                end
                cursor_q <= cursor_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: region test and cell lookup (combinational)
    // ------------------------------------------------------------------
    logic [9:0] dx;
    logic [2:0] col;
    logic [3:0] row;
    logic       in_x;
    logic       in_y;
    logic       sel_vld;
    logic [1:0] sel_code;

    assign dx   = pixel_x - 10'(TEXT_X);
    assign col  = dx[2:0];
    // Only the low four bits of the row offset matter; mod-16 subtraction gives them directly.
    assign row  = pixel_y[3:0] - 4'(TEXT_Y);
    assign in_x = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI);
    assign in_y = ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);

    // dx[9:3] can exceed the cell count outside the region; a compare-based
    // mux keeps the lookup in range and yields an invalid blank cell there.
    always_comb begin
        sel_vld  = 1'b0;
        sel_code = 2'd0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (dx[9:3] == 7'(i)) begin
                sel_vld  = cell_vld[i];
                sel_code = cell_code[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: ROM address / enable
    // ------------------------------------------------------------------
    logic [2:0] col_q;
    logic       von_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= 6'd0;
            rom_en   <= 1'b0;
            col_q    <= 3'd0;
            von_q    <= 1'b0;
        end else begin
            rom_addr <= (in_x && in_y) ? {sel_code, row} : 6'd0;
            rom_en   <= video_on && in_x && in_y && sel_vld;
            col_q    <= col;
            von_q    <= video_on;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: column bit select (bit 7 is the leftmost pixel)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_on     <= 1'b0;
            video_on_out <= 1'b0;
        end else begin
            pixel_on     <= rom_en && rom_data[3'd7 - col_q];
            video_on_out <= von_q;
        end
    end

endmodule

// File: tb/tb_char_pixel_renderer.sv
module tb_char_pixel_renderer;

    logic       clk;
    logic       rst;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       wr_en;
    logic [1:0] wr_code;
    logic       del;
    logic       clr;
    logic [5:0] rom_addr;
    logic       rom_en;
    logic [7:0] rom_data;
    logic       pixel_on;
    logic       video_on_out;
    logic [3:0] cursor;
    logic       full;
    logic       empty;

    int tests = 0;
    int fails = 0;

    char_pixel_renderer #(.TEXT_X(64), .TEXT_Y(32), .N_CELLS(8)) dut (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .wr_en(wr_en), .wr_code(wr_code), .del(del), .clr(clr),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .pixel_on(pixel_on), .video_on_out(video_on_out),
        .cursor(cursor), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Character ROM model: F row0 FF else C0; Q row0 18, row15 1B, else 66;
    // H row7 FF else 81; X row0 C3 else 3C. Disabled ROM reads as zero.
    function automatic logic [7:0] glyph(input logic [1:0] code, input logic [3:0] r);
        case (code)
            2'd0:    return (r == 4'd0) ? 8'hFF : 8'hC0;
            2'd1:    return (r == 4'd0) ? 8'h18 : ((r == 4'd15) ? 8'h1B : 8'h66);
            2'd2:    return (r == 4'd7) ? 8'hFF : 8'h81;
            default: return (r == 4'd0) ? 8'hC3 : 8'h3C;
        endcase
    endfunction

    always_comb begin
        rom_data = 8'h00;
        if (rom_en) rom_data = glyph(rom_addr[5:4], rom_addr[3:0]);
    end

    task automatic idle_pixel();
        pixel_x  = 10'd0;
        pixel_y  = 10'd0;
        video_on = 1'b0;
    endtask

    task automatic wr(input logic [1:0] c);
        @(negedge clk);
        wr_en = 1'b1; wr_code = c;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic do_del();
        @(negedge clk);
        del = 1'b1;
        @(negedge clk);
        del = 1'b0;
    endtask

    // Scan eight pixels starting at x0 on row y; exp bit 7 belongs to x0.
    task automatic scan(input logic [9:0] y, input logic [9:0] x0, input logic [7:0] exp, input string name);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                tests++;
                if (pixel_on !== exp[9 - i]) begin
                    fails++;
                    $display("FAIL %s x=%0d y=%0d: pixel_on got %b expected %b", name, x0 + 10'(i - 2), y, pixel_on, exp[9 - i]);
                end
            end
            if (i < 8) begin
                pixel_x = x0 + 10'(i); pixel_y = y; video_on = 1'b1;
            end else begin
                idle_pixel();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        tests++;
        if (cursor !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: cursor=%0d empty=%b full=%b expected 0/1/0", cursor, empty, full);
        end
        tests++;
        if (rom_addr !== 6'd0 || rom_en !== 1'b0 || pixel_on !== 1'b0 || video_on_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: rom_addr=%0d rom_en=%b pixel_on=%b video_on_out=%b expected all 0", rom_addr, rom_en, pixel_on, video_on_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_f();
        wr(2'd0);
        tests++;
        if (cursor !== 4'd1 || empty !== 1'b0) begin
            fails++;
            $display("FAIL single_cursor: cursor=%0d empty=%b expected 1/0", cursor, empty);
        end
        @(negedge clk);
        pixel_x = 10'd64; pixel_y = 10'd32; video_on = 1'b1;
        @(negedge clk);
        tests++;
        if (rom_addr !== 6'b000000 || rom_en !== 1'b1) begin
            fails++;
            $display("FAIL single_rom: rom_addr=%b rom_en=%b expected 000000/1", rom_addr, rom_en);
        end
        idle_pixel();
        scan(10'd32, 10'd64, 8'hFF, "single_f_row0");
    endtask

    task automatic test_two_glyphs();
        do_clear();
        wr(2'd0);
        wr(2'd1);
        scan(10'd32, 10'd72, 8'b00011000, "q_row0");
        scan(10'd47, 10'd72, 8'b00011011, "q_row15");
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 0; i < 8; i++) wr(2'(i % 4));
        tests++;
        if (full !== 1'b1 || cursor !== 4'd8) begin
            fails++;
            $display("FAIL full_flag: full=%b cursor=%0d expected 1/8", full, cursor);
        end
        wr(2'd0);
        tests++;
        if (cursor !== 4'd8 || full !== 1'b1) begin
            fails++;
            $display("FAIL full_overwrite_cursor: cursor=%0d full=%b expected 8/1", cursor, full);
        end
        scan(10'd32, 10'd120, 8'hC3, "cell7_kept");
        do_del();
        tests++;
        if (cursor !== 4'd7 || full !== 1'b0) begin
            fails++;
            $display("FAIL del_cursor: cursor=%0d full=%b expected 7/0", cursor, full);
        end
        scan(10'd32, 10'd120, 8'h00, "cell7_blank");
        scan(10'd32, 10'd112, 8'h81, "cell6_kept");
    endtask

    task automatic test_priority();
        do_clear();
        for (int i = 0; i < 3; i++) wr(2'd1);
        tests++;
        if (cursor !== 4'd3) begin
            fails++;
            $display("FAIL prio_setup: cursor=%0d expected 3", cursor);
        end
        @(negedge clk);
        wr_en = 1'b1; wr_code = 2'd2; del = 1'b1; clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; del = 1'b0; clr = 1'b0;
        tests++;
        if (cursor !== 4'd0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL prio_clr: cursor=%0d empty=%b expected 0/1", cursor, empty);
        end
        scan(10'd32, 10'd64, 8'h00, "prio_cell0");
        scan(10'd32, 10'd72, 8'h00, "prio_cell1");
        scan(10'd32, 10'd80, 8'h00, "prio_cell2");
        do_del();
        tests++;
        if (cursor !== 4'd0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL del_empty: cursor=%0d empty=%b expected 0/1", cursor, empty);
        end
        // del outranks wr_en: cursor 2 -> 1, no write.
        wr(2'd2);
        wr(2'd2);
        @(negedge clk);
        wr_en = 1'b1; wr_code = 2'd3; del = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; del = 1'b0;
        tests++;
        if (cursor !== 4'd1) begin
            fails++;
            $display("FAIL prio_del_wr: cursor=%0d expected 1", cursor);
        end
        scan(10'd32, 10'd64, 8'h81, "prio_h_kept");
        scan(10'd32, 10'd72, 8'h00, "prio_cell1_blank");
    endtask

    task automatic test_region();
        logic [9:0] vx [9];
        logic [9:0] vy [9];
        logic       vv [9];
        logic       ve [9];
        logic       vp [9];
        logic       seq [5];
        vx = '{10'd63, 10'd128, 10'd64, 10'd64, 10'd64, 10'd64, 10'd127, 10'd65, 10'd66};
        vy = '{10'd32, 10'd32,  10'd31, 10'd48, 10'd32, 10'd32, 10'd32,  10'd47, 10'd47};
        vv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ve = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_clear();
        for (int i = 0; i < 8; i++) wr(2'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pixel_x = vx[i]; pixel_y = vy[i]; video_on = vv[i];
            @(negedge clk);
            tests++;
            if (rom_en !== ve[i]) begin
                fails++;
                $display("FAIL region_rom_en (%0d,%0d,v=%b): got %b expected %b", vx[i], vy[i], vv[i], rom_en, ve[i]);
            end
            idle_pixel();
            @(negedge clk);
            tests++;
            if (pixel_on !== vp[i]) begin
                fails++;
                $display("FAIL region_pixel (%0d,%0d,v=%b): got %b expected %b", vx[i], vy[i], vv[i], pixel_on, vp[i]);
            end
        end
        seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                tests++;
                if (video_on_out !== seq[i - 2]) begin
                    fails++;
                    $display("FAIL video_delay step %0d: got %b expected %b", i - 2, video_on_out, seq[i - 2]);
                end
            end
            video_on = (i < 5) ? seq[i] : 1'b0;
        end
        idle_pixel();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pixel_x = 10'd64; pixel_y = 10'd32; video_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (pixel_on !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pre: pixel_on got %b expected 1", pixel_on);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (pixel_on !== 1'b0 || rom_en !== 1'b0 || cursor !== 4'd0 || video_on_out !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_async: pixel_on=%b rom_en=%b cursor=%0d video_on_out=%b expected 0/0/0/0", pixel_on, rom_en, cursor, video_on_out);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_pixel();
        wr(2'd0);
        @(negedge clk);
        pixel_x = 10'd64; pixel_y = 10'd32; video_on = 1'b1;
        @(negedge clk);
        tests++;
        if (rom_en !== 1'b1) begin
            fails++;
            $display("FAIL rst_after_rom_en: got %b expected 1", rom_en);
        end
        idle_pixel();
        @(negedge clk);
        tests++;
        if (pixel_on !== 1'b1 || video_on_out !== 1'b1) begin
            fails++;
            $display("FAIL rst_after_pixel: pixel_on=%b video_on_out=%b expected 1/1", pixel_on, video_on_out);
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_code = 2'd0; del = 1'b0; clr = 1'b0;
        idle_pixel();
        test_reset();
        test_single_f();
        test_two_glyphs();
        test_full();
        test_priority();
        test_region();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
